// File: rtl/sincos_seq.sv
// sincos_seq: sequential sine/cosine generator.
// The angle (degrees) is reduced modulo 360 by repeated subtraction, then folded
// onto a quarter-wave table T[0..90] to produce both sin and cos in fixed point.
module sincos_seq #(
  parameter int FRAC_W  = 16,
  parameter int ANGLE_W = 10,
  parameter int OUT_W   = FRAC_W + 2
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ANGLE_W-1:0]      angle,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] sin_out,
  output logic signed [OUT_W-1:0] cos_out,
  output logic [1:0]              quadrant
);

  localparam int  TW = FRAC_W + 1;
  // Working register must hold at least 359 even for narrow angle ports.
  localparam int  AW = (ANGLE_W > 9) ? ANGLE_W : 9;
  localparam real PI = 3.14159265358979323846;

  // T[d] = floor(2^FRAC_W * sin(d deg) + 1e-9); Taylor series is accurate to
  // ~1e-16 on [0, pi/2], so the epsilon keeps exact entries (30, 90) exact.
  function automatic logic [TW-1:0] sin_entry(input int d);
    real x;
    real term;
    real sum;
    real scale;
    x    = real'(d) * PI / 180.0;
    term = x;
    sum  = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / ((2.0 * n) * (2.0 * n + 1.0));
      sum  = sum + term;
    end
    scale = 1.0;
    for (int i = 0; i < FRAC_W; i++) scale = scale * 2.0;
    return TW'($rtoi(sum * scale + 1.0e-9));
  endfunction

  logic [TW-1:0] rom [0:90];
  for (genvar g = 0; g <= 90; g++) begin : g_rom
    localparam logic [TW-1:0] ENTRY = sin_entry(g);
    assign rom[g] = ENTRY;
  end

  typedef enum logic [1:0] {S_IDLE, S_REDUCE, S_LOOKUP, S_OUT} state_t;

  state_t                  state_q, state_d;
  logic [AW-1:0]           a_q, a_d;
  logic signed [OUT_W-1:0] sin_q, sin_d;
  logic signed [OUT_W-1:0] cos_q, cos_d;
  logic [1:0]              quad_q, quad_d;

  logic [1:0]              region;
  logic [6:0]              r;
  logic [6:0]              sin_idx, cos_idx;
  logic signed [OUT_W-1:0] sin_mag, cos_mag;

  // Region/offset decode of the reduced angle and the two quarter-table reads
  always_comb begin
    region = 2'd3;
    r      = 7'(a_q - AW'(270));
    if (a_q < AW'(90)) begin
      region = 2'd0;
      r      = 7'(a_q);
    end else if (a_q < AW'(180)) begin
      region = 2'd1;
      r      = 7'(a_q - AW'(90));
    end else if (a_q < AW'(270)) begin
      region = 2'd2;
      r      = 7'(a_q - AW'(180));
    end
    // Odd regions swap which function reads T[r] and which reads T[90-r].
    sin_idx = region[0] ? (7'd90 - r) : r;
    cos_idx = region[0] ? r : (7'd90 - r);
    sin_mag = $signed({1'b0, rom[sin_idx]});
    cos_mag = $signed({1'b0, rom[cos_idx]});
  end

  // Next-state logic: accept, reduce by 360 per cycle, fold into outputs, hold
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    sin_d   = sin_q;
    cos_d   = cos_q;
    quad_d  = quad_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = AW'(angle);
          state_d = S_REDUCE;
        end
      end
      S_REDUCE: begin
        if (a_q >= AW'(360)) a_d = a_q - AW'(360);
        else                 state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        // sin is negative in regions 2,3; cos in regions 1,2.
        sin_d   = region[1] ? -sin_mag : sin_mag;
        cos_d   = (region[1] ^ region[0]) ? -cos_mag : cos_mag;
        quad_d  = region;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, working angle and result registers with synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      sin_q   <= '0;
      cos_q   <= '0;
      quad_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      sin_q   <= sin_d;
      cos_q   <= cos_d;
      quad_q  <= quad_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_OUT);
  assign sin_out   = sin_q;
  assign cos_out   = cos_q;
  assign quadrant  = quad_q;

endmodule
